if_id_stage: RTL and testbench
==============================

// Module: if_id_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register for the 16-bit pipelined core.
//  Owns the PC, addresses instruction memory, and latches fetched instr/PC for decode.
//  Consumes the load-use stall from hazard detection and the branch redirect from EX.
//  Also provides a halt state and a saturating stall-cycle counter for perf checks.
// PARAMETERS
//  PC_WIDTH        16       PC / instruction-memory word-address width
//  INSTR_WIDTH     16       instruction width
//  RESET_PC        0        PC value loaded on reset
//  NOP_INSTR       16'h0000 encoding inserted into IF/ID on flush/reset
//  STALL_CNT_WIDTH 16       width of saturating stall counter
// PORTS
//  clk            in   1            clock, all state updates on rising edge
//  rst            in   1            asynchronous reset, active-high
//  hazard         in   1            load-use stall request for the instr currently in ID
//  branch_taken   in   1            EX resolved a taken branch/jump this cycle
//  branch_target  in   PC_WIDTH     redirect address, valid with branch_taken
//  halt_req       in   1            decode identified a halt instr in ID (qualified by valid_ID)
//  imem_addr      out  PC_WIDTH     instruction-memory address (= PC)
//  imem_data      in   INSTR_WIDTH  instruction word, combinational read of imem_addr
//  instr_ID       out  INSTR_WIDTH  IF/ID instruction
//  pc_ID          out  PC_WIDTH     PC of instr_ID
//  pc_plus1_ID    out  PC_WIDTH     pc_ID + 1 (mod 2^PC_WIDTH), link/branch base
//  valid_ID       out  1            instr_ID is a real instruction (0 = bubble)
//  halted         out  1            core halted; fetch frozen
//  stall_cycles   out  STALL_CNT_WIDTH  count of hazard-stall cycles, saturating
// BEHAVIOUR
//  - Reset (async, immediate): pc=RESET_PC, instr_ID=NOP_INSTR, pc_ID=0, valid_ID=0,
//    state=RUN, halted=0, stall_cycles=0. Reset mid-stall/mid-halt aborts everything.
//  - imem_addr = pc combinationally; fetch latency 1 cycle (imem_data captured at edge).
//  - PC word-addressed: increment by 1; wraps 2^PC_WIDTH-1 -> 0 silently.
//  - FSM: RUN, HALTED. HALTED exits only via rst.
//  - Per-edge priority in RUN (highest first):
//    1 branch_taken: pc<=branch_target; IF/ID<=NOP_INSTR, valid_ID<=0 (flush).
//      Overrides hazard and halt_req same cycle (younger ID instr is squashed).
//    2 halt_req & valid_ID: state<=HALTED; pc holds; IF/ID<=NOP_INSTR, valid_ID<=0.
//      Overrides hazard.
//    3 hazard: pc, instr_ID, pc_ID, valid_ID all hold; stall_cycles+=1 unless all-ones.
//      Hazard counted only if valid_ID=1 (bubble never stalls; hazard ignored).
//    4 else: instr_ID<=imem_data, pc_ID<=pc, valid_ID<=1, pc<=pc+1.
//  - HALTED: pc, IF/ID, stall_cycles frozen; valid_ID=0; halted=1; all inputs ignored.
//  - halt_req with valid_ID=0 ignored.
//  - Multi-cycle hazard: holds for every asserted cycle; counter increments each cycle.
//  - stall_cycles saturates at 2^STALL_CNT_WIDTH-1, never wraps.
//  - pc_plus1_ID purely combinational from pc_ID.
// TESTING
//  T1 rst high then low, imem[n]=16'h1000+n -> imem_addr 0,1,2..; instr_ID 1000,1001..
//     valid_ID=1 from 2nd edge; pc_ID lags imem_addr by 1.
//  T2 hazard=1 for 2 cycles while instr_ID=1003 -> instr_ID/pc_ID/imem_addr held 2 cycles,
//     then resume 1004; stall_cycles=2.
//  T3 hazard=1 and branch_taken=1, branch_target=16'h0040 same cycle -> next imem_addr=40,
//     valid_ID=0, instr_ID=NOP_INSTR; stall_cycles unchanged; next edge instr_ID=imem[40].
//  T4 halt_req=1 with valid_ID=1 -> halted=1, valid_ID=0, imem_addr frozen for 10 cycles
//     despite hazard/branch_taken pulses; rst clears halted, imem_addr=RESET_PC.
//  T5 branch_target=16'hFFFF -> fetch FFFF then 0000; pc_plus1_ID=0000 when pc_ID=FFFF.
//  T6 STALL_CNT_WIDTH=3, hazard held 10 cycles (valid_ID=1) -> stall_cycles sticks at 7;
//     async rst asserted mid-stall between edges -> outputs reset immediately.

Source files
------------

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, drives instruction memory,
// and latches the fetched word/PC for decode, with flush, load-use stall and halt.
module if_id_stage #(
    parameter int                          PC_WIDTH        = 16,
    parameter int                          INSTR_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]         RESET_PC        = '0,
    parameter logic [INSTR_WIDTH-1:0]      NOP_INSTR       = '0,
    parameter int                          STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hazard,
    input  logic                       branch_taken,
    input  logic [PC_WIDTH-1:0]        branch_target,
    input  logic                       halt_req,
    output logic [PC_WIDTH-1:0]        imem_addr,
    input  logic [INSTR_WIDTH-1:0]     imem_data,
    output logic [INSTR_WIDTH-1:0]     instr_ID,
    output logic [PC_WIDTH-1:0]        pc_ID,
    output logic [PC_WIDTH-1:0]        pc_plus1_ID,
    output logic                       valid_ID,
    output logic                       halted,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [PC_WIDTH-1:0]        PC_ONE    = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = {STALL_CNT_WIDTH{1'b1}};

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic                       run_s;
    logic                       halt_take_s;
    logic                       stall_take_s;
    logic [PC_WIDTH-1:0]        pc_r;
    logic [INSTR_WIDTH-1:0]     instr_r;
    logic [PC_WIDTH-1:0]        pc_id_r;
    logic                       valid_r;
    logic                       halted_r;
    logic [STALL_CNT_WIDTH-1:0] stall_r;

    // A taken branch squashes the ID instruction, so it outranks halt and stall.
    assign halt_take_s  = run_s & ~branch_taken & halt_req & valid_r;
    assign stall_take_s = run_s & ~branch_taken & ~(halt_req & valid_r) & hazard & valid_r;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; HALTED is left only through reset
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_take_s) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // FSM output decode
    always_comb begin
        run_s = 1'b0;
        case (state_r)
            ST_RUN:    run_s = 1'b1;
            ST_HALTED: run_s = 1'b0;
            default:   run_s = 1'b0;
        endcase
    end

    // PC, IF/ID register, halt flag and stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            instr_r  <= NOP_INSTR;
            pc_id_r  <= '0;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
            stall_r  <= '0;
        end else if (!run_s) begin
            halted_r <= 1'b1;
            valid_r  <= 1'b0;
        end else if (branch_taken) begin
            pc_r    <= branch_target;
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
        end else if (halt_take_s) begin
            instr_r  <= NOP_INSTR;
            valid_r  <= 1'b0;
            halted_r <= 1'b1;
        end else if (stall_take_s) begin
            if (stall_r != STALL_MAX) begin
                stall_r <= stall_r + STALL_ONE;
            end else begin
                stall_r <= stall_r;
            end
        end else begin
            instr_r <= imem_data;
            pc_id_r <= pc_r;
            valid_r <= 1'b1;
            pc_r    <= pc_r + PC_ONE;
        end
    end

    assign imem_addr    = pc_r;
    assign instr_ID     = instr_r;
    assign pc_ID        = pc_id_r;
    assign pc_plus1_ID  = pc_id_r + PC_ONE;
    assign valid_ID     = valid_r;
    assign halted       = halted_r;
    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: sequential fetch, stall, flush, wrap,
// counter saturation (3-bit counter), halt and async reset.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic        hazard;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr_ID;
    logic [15:0] pc_ID;
    logic [15:0] pc_plus1_ID;
    logic        valid_ID;
    logic        halted;
    logic [2:0]  stall_cycles;

    logic [15:0] valid_x;
    logic [15:0] halted_x;
    logic [15:0] stall_x;

    int n_total;
    int n_bad;

    if_id_stage #(
        .PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000),
        .NOP_INSTR(16'h0000), .STALL_CNT_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .imem_addr(imem_addr),
        .imem_data(imem_data), .instr_ID(instr_ID), .pc_ID(pc_ID),
        .pc_plus1_ID(pc_plus1_ID), .valid_ID(valid_ID), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    // imem[n] = 16'h1000 + n
    assign imem_data = 16'h1000 + imem_addr;
    assign valid_x   = {15'h0000, valid_ID};
    assign halted_x  = {15'h0000, halted};
    assign stall_x   = {13'h0000, stall_cycles};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_total = n_total + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        rst = 1'b1;
        hazard = 1'b0;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        halt_req = 1'b0;
        step();
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_instr", instr_ID, 16'h0000);
        check("rst_pcid", pc_ID, 16'h0000);
        check("rst_valid", valid_x, 16'h0000);
        check("rst_halted", halted_x, 16'h0000);
        check("rst_stall", stall_x, 16'h0000);
        rst = 1'b0;

        // T1 sequential fetch
        for (int n = 0; n < 4; n++) begin
            step();
            check("t1_instr", instr_ID, 16'h1000 + 16'(n));
            check("t1_pcid", pc_ID, 16'(n));
            check("t1_addr", imem_addr, 16'(n + 1));
            check("t1_valid", valid_x, 16'h0001);
        end

        // T2 two-cycle load-use stall on 1003
        hazard = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step();
            check("t2_hold_instr", instr_ID, 16'h1003);
            check("t2_hold_pcid", pc_ID, 16'h0003);
            check("t2_hold_addr", imem_addr, 16'h0004);
            check("t2_stall", stall_x, 16'(k));
        end
        hazard = 1'b0;
        step();
        check("t2_resume", instr_ID, 16'h1004);
        check("t2_resume_addr", imem_addr, 16'h0005);
        check("t2_stall_after", stall_x, 16'h0002);

        // T3 branch beats hazard
        hazard = 1'b1;
        branch_taken = 1'b1;
        branch_target = 16'h0040;
        step();
        check("t3_addr", imem_addr, 16'h0040);
        check("t3_valid", valid_x, 16'h0000);
        check("t3_instr", instr_ID, 16'h0000);
        check("t3_stall", stall_x, 16'h0002);
        branch_taken = 1'b0;
        // hazard still high while ID holds a bubble: ignored
        step();
        check("t3_fetch", instr_ID, 16'h1040);
        check("t3_pcid", pc_ID, 16'h0040);
        check("t3_valid2", valid_x, 16'h0001);
        check("t3_bubble_nostall", stall_x, 16'h0002);
        hazard = 1'b0;

        // T5 branch to FFFF beats halt_req; halt_req on bubble ignored; wrap
        branch_taken = 1'b1;
        branch_target = 16'hFFFF;
        halt_req = 1'b1;
        step();
        check("t5_addr", imem_addr, 16'hFFFF);
        check("t5_nohalt", halted_x, 16'h0000);
        check("t5_valid", valid_x, 16'h0000);
        branch_taken = 1'b0;
        step();
        check("t5_bubble_halt_ignored", halted_x, 16'h0000);
        check("t5_instr", instr_ID, 16'h0FFF);
        check("t5_pcid", pc_ID, 16'hFFFF);
        check("t5_plus1", pc_plus1_ID, 16'h0000);
        check("t5_wrap", imem_addr, 16'h0000);
        halt_req = 1'b0;
        step();
        check("t5_instr0", instr_ID, 16'h1000);
        check("t5_plus1b", pc_plus1_ID, 16'h0001);

        // T6 saturation at 7 with a 3-bit counter, then async reset mid-stall
        hazard = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t6_stall", stall_x, 16'((2 + k > 7) ? 7 : 2 + k));
            check("t6_hold", instr_ID, 16'h1000);
        end
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_addr", imem_addr, 16'h0000);
        check("t6_async_stall", stall_x, 16'h0000);
        check("t6_async_valid", valid_x, 16'h0000);
        check("t6_async_instr", instr_ID, 16'h0000);
        step();
        rst = 1'b0;
        hazard = 1'b0;
        step();
        check("t6_restart", instr_ID, 16'h1000);
        step();
        check("t6_restart2", instr_ID, 16'h1001);
        check("t6_restart_addr", imem_addr, 16'h0002);

        // T4 halt, then pulses must be ignored
        halt_req = 1'b1;
        step();
        check("t4_halted", halted_x, 16'h0001);
        check("t4_valid", valid_x, 16'h0000);
        check("t4_addr", imem_addr, 16'h0002);
        halt_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            hazard = k[0];
            branch_taken = ~k[0];
            branch_target = 16'h0055;
            step();
            check("t4_frozen_addr", imem_addr, 16'h0002);
            check("t4_frozen_halt", halted_x, 16'h0001);
            check("t4_frozen_valid", valid_x, 16'h0000);
            check("t4_frozen_stall", stall_x, 16'h0000);
        end
        hazard = 1'b0;
        branch_taken = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t4_rst_halt", halted_x, 16'h0000);
        check("t4_rst_addr", imem_addr, 16'h0000);
        step();
        rst = 1'b0;
        step();
        check("t4_run_again", instr_ID, 16'h1000);
        check("t4_run_valid", valid_x, 16'h0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
